// File: rtl/kgp_pkg.sv
// Shared constants for the iterative multiplier: operand width, counter width
// and FSM state encoding.
package kgp_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
endpackage

// File: rtl/kgp_negate2w.sv
// Combinational two's-complement negate.
// Defaults to the full product width and is also used at operand width.
module kgp_negate2w
    import kgp_pkg::*;
#(
    parameter int N = 2 * WIDTH
) (
    input  logic [N-1:0] a_i,
    output logic [N-1:0] y_o
);
    assign y_o = ~a_i + N'(1);
endmodule

// File: rtl/kgp_mul_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier.
// The low product word is written back through WR/RSW, and the high word is held in HI.
module kgp_mul_unit
    import kgp_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             SIGNED_OP,
    input  logic [WIDTH-1:0] RS_IN,
    input  logic [WIDTH-1:0] RT_IN,
    output logic             STALL,
    output logic             WR,
    output logic [WIDTH-1:0] RSW,
    output logic [WIDTH-1:0] HI,
    output logic             DONE
);
    localparam int PW = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             sign_q, sign_d;
    logic             stall_q, stall_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] rsw_q, rsw_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH-1:0] rs_neg, rt_neg, rs_mag, rt_mag;
    logic [PW-1:0]    acc_step, prod_neg, prod_final;

    kgp_negate2w #(.N(WIDTH)) u_neg_rs (.a_i(RS_IN), .y_o(rs_neg));
    kgp_negate2w #(.N(WIDTH)) u_neg_rt (.a_i(RT_IN), .y_o(rt_neg));
    kgp_negate2w #(.N(PW))    u_neg_p  (.a_i(acc_step), .y_o(prod_neg));

    // The magnitude of -2^31 wraps to 0x8000_0000, which is correct when it is treated as unsigned.
    assign rs_mag = (SIGNED_OP && RS_IN[WIDTH-1]) ? rs_neg : RS_IN;
    assign rt_mag = (SIGNED_OP && RT_IN[WIDTH-1]) ? rt_neg : RT_IN;

    assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_final = sign_q ? prod_neg : acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        wr_d     = 1'b0;
        rsw_d    = rsw_q;
        hi_d     = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sign_d   = SIGNED_OP & (RS_IN[WIDTH-1] ^ RT_IN[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, rs_mag};
                    mplier_d = rt_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_WB;
                    wr_d    = 1'b1;
                    rsw_d   = prod_final[WIDTH-1:0];
                    hi_d    = prod_final[PW-1:WIDTH];
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            stall_q  <= 1'b0;
            wr_q     <= 1'b0;
            rsw_q    <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            stall_q  <= stall_d;
            wr_q     <= wr_d;
            rsw_q    <= rsw_d;
            hi_q     <= hi_d;
        end
    end

    assign STALL = stall_q;
    assign WR    = wr_q;
    assign DONE  = wr_q;
    assign RSW   = rsw_q;
    assign HI    = hi_q;
endmodule

// File: tb/tb_kgp_mul_unit.sv
// Scoreboard bench for kgp_mul_unit: expected products come from a 64-bit
// arithmetic reference model, and a negedge monitor checks every write-back.
module tb_kgp_mul_unit;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic        START = 1'b0;
    logic        SIGNED_OP = 1'b0;
    logic [31:0] RS_IN = '0;
    logic [31:0] RT_IN = '0;
    logic        STALL, WR, DONE;
    logic [31:0] RSW, HI;

    int n_pass = 0;
    int n_total = 0;
    int n_issued = 0;
    int n_wr = 0;
    logic [63:0] exp_q[$];

    kgp_mul_unit dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .SIGNED_OP(SIGNED_OP),
        .RS_IN(RS_IN), .RT_IN(RT_IN), .STALL(STALL), .WR(WR),
        .RSW(RSW), .HI(HI), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'b0, a});
            pb = longint'({32'b0, b});
        end
        return 64'(pa * pb);
    endfunction

    // Monitor: every write-back must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge CLK);
            if (RSTN && (WR || DONE)) begin
                chk("done_eq_wr", 64'(DONE), 64'(WR));
                if (WR) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wr", 64'(WR), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        n_wr++;
                        chk("wb_rsw", 64'(RSW), 64'(e[31:0]));
                        chk("wb_hi", 64'(HI), 64'(e[63:32]));
                        $display("WB  rsw=0x%08h hi=0x%08h exp=0x%016h", RSW, HI, e);
                    end
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_stall"}, 64'(STALL), 64'd0);
        chk({tag, "_wr"}, 64'(WR), 64'd0);
        chk({tag, "_done"}, 64'(DONE), 64'd0);
        chk({tag, "_rsw"}, 64'(RSW), 64'd0);
        chk({tag, "_hi"}, 64'(HI), 64'd0);
    endtask

    // A single operation. When hold=1, START stays high and the operands churn until the bench is back in IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold);
        logic [63:0] e;
        int cyc;
        e = ref_mul(a, b, s);
        @(negedge CLK);
        START = 1'b1; SIGNED_OP = s; RS_IN = a; RT_IN = b;
        exp_q.push_back(e);
        n_issued++;
        $display("OP  a=0x%08h b=0x%08h signed=%0d hold=%0d", a, b, s, hold);
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) START = 1'b0;
        cyc = 0;
        while (STALL && cyc < 60) begin
            cyc++;
            if (hold) begin
                RS_IN = $urandom; RT_IN = $urandom; SIGNED_OP = 1'($urandom);
            end
            @(negedge CLK);
        end
        START = 1'b0;
        chk("stall_cycles", 64'(cyc), 64'd33);
        chk("rsw_hold", 64'(RSW), 64'(e[31:0]));
        chk("hi_hold", 64'(HI), 64'(e[63:32]));
        if (hold) begin
            repeat (3) begin
                @(negedge CLK);
                chk("no_reaccept", 64'(STALL), 64'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RSTN = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        run_op(32'd7, 32'd6, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        run_op(32'd0, 32'h1234_5678, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b1, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'b0);
        end

        // Abort in the middle of RUN. The preceding op leaves HI/RSW non-zero.
        run_op(32'hFFFF_FFF0, 32'h7777_7777, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b1; SIGNED_OP = 1'b0; RS_IN = 32'hABCD_0123; RT_IN = 32'h0FED_CBA9;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RSTN = 1'b0;
        #1 check_zero_outputs("abort");
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (40) @(negedge CLK);
        check_zero_outputs("post_abort");
        run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);

        repeat (3) @(negedge CLK);
        chk("write_count", 64'(n_wr), 64'(n_issued));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
